adder_16bit: RTL and testbench



---
 rtl/adder_16bit.sv | 154 +++++++++++++++
 tb/tb_adder_16bit.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/adder_16bit.sv
// ---------------------------------------------------------------------------
// adder_16bit
//
// Purpose:
//   16-bit two's-complement / unsigned adder used as the processor datapath
//   adder. The sum and the C/V/Z/N flags are purely combinational from A and
//   B. A registered copy of the sum and flags is captured every rising clock
//   edge for downstream control logic. A sticky overflow bit remembers any
//   overflow seen since the last reset.
//
// Build option:
//   ADDER_16_BIT_CLA_EN  defined   -> four 4-bit carry-lookahead groups with a
//                                     second-level lookahead for c4/c8/c12.
//                        undefined -> 16-stage ripple-carry chain.
//   Both builds give bit-identical results; only structure differs.
//
// Ports:
//   clk       in   1   rising-edge clock for the capture registers
//   reset     in   1   synchronous, active-high; clears registered outputs
//   A         in  16   operand A
//   B         in  16   operand B
//   R         out 16   combinational sum, (A + B) mod 2^16
//   C         out  1   combinational carry out of bit 15
//   V         out  1   combinational signed overflow
//   Z         out  1   combinational, R == 0
//   N         out  1   combinational, R[15]
//   R_q       out 16   registered R
//   flags_q   out  4   registered {C, V, Z, N}
//   V_sticky  out  1   registered, set by any sampled V, cleared by reset
// ---------------------------------------------------------------------------
module adder_16bit (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] A,
  input  logic [15:0] B,
  output logic [15:0] R,
  output logic        C,
  output logic        V,
  output logic        Z,
  output logic        N,
  output logic [15:0] R_q,
  output logic [3:0]  flags_q,
  output logic        V_sticky
);

  logic [15:0] sumBits;
  logic        carryOut;

`ifdef ADDER_16_BIT_CLA_EN

  logic [15:0] bitGen;
  logic [15:0] bitProp;
  logic [3:0]  groupGen;
  logic [3:0]  groupProp;
  logic [3:0]  groupCarryIn;
  logic        carryIn;

  // The adder has no carry-in port, so the chain starts from zero.
  assign carryIn = 1'b0;
  assign bitGen  = A & B;
  assign bitProp = A ^ B;

  // Each 4-bit group derives its own group generate/propagate and expands its
  // incoming group carry into per-bit carries in parallel.
  for (genvar g = 0; g < 4; g++) begin : gCla
    logic [3:0] p;
    logic [3:0] gn;
    logic       cIn;
    logic       c1;
    logic       c2;
    logic       c3;

    assign p   = bitProp[4*g +: 4];
    assign gn  = bitGen[4*g +: 4];
    assign cIn = groupCarryIn[g];

    assign groupGen[g]  = gn[3] | (p[3] & gn[2]) | (p[3] & p[2] & gn[1])
                        | (p[3] & p[2] & p[1] & gn[0]);
    assign groupProp[g] = &p;

    assign c1 = gn[0] | (p[0] & cIn);
    assign c2 = gn[1] | (p[1] & gn[0]) | (p[1] & p[0] & cIn);
    assign c3 = gn[2] | (p[2] & gn[1]) | (p[2] & p[1] & gn[0])
              | (p[2] & p[1] & p[0] & cIn);

    assign sumBits[4*g +: 4] = p ^ {c3, c2, c1, cIn};
  end

  // Second-level lookahead: every group carry is a flat sum of products of
  // group generate/propagate terms, so c4, c8, c12 and c16 resolve together
  // instead of rippling group to group.
  assign groupCarryIn[0] = carryIn;
  assign groupCarryIn[1] = groupGen[0] | (groupProp[0] & carryIn);
  assign groupCarryIn[2] = groupGen[1] | (groupProp[1] & groupGen[0])
                         | (groupProp[1] & groupProp[0] & carryIn);
  assign groupCarryIn[3] = groupGen[2] | (groupProp[2] & groupGen[1])
                         | (groupProp[2] & groupProp[1] & groupGen[0])
                         | (groupProp[2] & groupProp[1] & groupProp[0] & carryIn);
  assign carryOut        = groupGen[3] | (groupProp[3] & groupGen[2])
                         | (groupProp[3] & groupProp[2] & groupGen[1])
                         | (groupProp[3] & groupProp[2] & groupProp[1] & groupGen[0])
                         | (groupProp[3] & groupProp[2] & groupProp[1]
                            & groupProp[0] & carryIn);

`else

  logic carryChain;

  // Ripple-carry chain: the carry is threaded bit by bit through sixteen full
  // adders. A scalar carry variable keeps the chain free of a self-dependent
  // vector.
  always_comb begin
    sumBits    = '0;
    carryChain = 1'b0;
    for (int i = 0; i < 16; i++) begin
      sumBits[i] = A[i] ^ B[i] ^ carryChain;
      carryChain = (A[i] & B[i]) | (carryChain & (A[i] ^ B[i]));
    end
    carryOut = carryChain;
  end

`endif

  // Flags are pure functions of the sum and operand signs. Overflow means
  // both operands share a sign that the result does not.
  assign R = sumBits;
  assign C = carryOut;
  assign V = (A[15] == B[15]) && (sumBits[15] != A[15]);
  assign Z = ~|sumBits;
  assign N = sumBits[15];

  logic [15:0] R_d;
  logic [3:0]  flags_d;
  logic        vSticky_d;

  assign R_d       = R;
  assign flags_d   = {C, V, Z, N};
  assign vSticky_d = V_sticky | V;

  // Capture registers. Reset is synchronous and takes priority, so an
  // overflow on the same edge as reset does not set the sticky bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      R_q      <= '0;
      flags_q  <= '0;
      V_sticky <= 1'b0;
    end else begin
      R_q      <= R_d;
      flags_q  <= flags_d;
      V_sticky <= vSticky_d;
    end
  end

endmodule

// File: tb/tb_adder_16bit.sv
// ---------------------------------------------------------------------------
// tb_adder_16bit
//
// Purpose:
//   Scoreboard bench for adder_16bit. Stimulus pushes the expected
//   combinational and registered responses into queues; two monitors pop and
//   compare when the DUT presents the corresponding output.
// ---------------------------------------------------------------------------
module tb_adder_16bit;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] r;
    logic [3:0]  f;
  } combExp_t;

  typedef struct {
    logic [15:0] rq;
    logic [3:0]  fq;
    logic        vs;
  } regExp_t;

  logic        clk;
  logic        clkEnable;
  logic        reset;
  logic [15:0] A;
  logic [15:0] B;
  logic [15:0] R;
  logic        C;
  logic        V;
  logic        Z;
  logic        N;
  logic [15:0] R_q;
  logic [3:0]  flags_q;
  logic        V_sticky;

  int testsRun;
  int testsFailed;

  combExp_t combQ[$];
  regExp_t  regQ[$];
  event     combReady;

  adder_16bit dut (
    .clk      (clk),
    .reset    (reset),
    .A        (A),
    .B        (B),
    .R        (R),
    .C        (C),
    .V        (V),
    .Z        (Z),
    .N        (N),
    .R_q      (R_q),
    .flags_q  (flags_q),
    .V_sticky (V_sticky)
  );

  // Clock only runs once the registered phase begins; the sweep is done with
  // the clock held low.
  initial clk = 1'b0;
  always #5 if (clkEnable) clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Combinational monitor: one expected entry per strobe.
  initial begin
    combExp_t e;
    forever begin
      @(combReady);
      if (combQ.size() == 0) begin
        checkOutput("comb_queue_nonempty", 32'd0, 32'd1);
      end else begin
        e = combQ.pop_front();
        checkOutput($sformatf("R(%h+%h)", e.a, e.b), {16'd0, R}, {16'd0, e.r});
        checkOutput($sformatf("CVZN(%h+%h)", e.a, e.b), {28'd0, C, V, Z, N},
                    {28'd0, e.f});
      end
    end
  end

  // Registered monitor: 1 ns after each rising edge, compare against the
  // entry pushed for that edge.
  initial begin
    regExp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (regQ.size() != 0) begin
        e = regQ.pop_front();
        checkOutput("R_q", {16'd0, R_q}, {16'd0, e.rq});
        checkOutput("flags_q", {28'd0, flags_q}, {28'd0, e.fq});
        checkOutput("V_sticky", {31'd0, V_sticky}, {31'd0, e.vs});
      end
    end
  end

  // Drive one operand pair (without clock), then strobe the comb monitor.
  task automatic applyComb(input logic [15:0] a, input logic [15:0] b,
                           input logic [15:0] expR, input logic [3:0] expF);
    combExp_t e;
    A = a;
    B = b;
    e.a = a;
    e.b = b;
    e.r = expR;
    e.f = expF;
    combQ.push_back(e);
    #1;
    ->combReady;
    #1;
  endtask

  // Drive one clocked step on the falling edge: comb expectation plus the
  // registered values expected after the following rising edge.
  task automatic applyStimulus(input logic rst, input logic [15:0] a,
                               input logic [15:0] b, input logic [15:0] expR,
                               input logic [3:0] expF, input logic [15:0] expRq,
                               input logic [3:0] expFq, input logic expVs);
    regExp_t r;
    @(negedge clk);
    reset = rst;
    r.rq = expRq;
    r.fq = expFq;
    r.vs = expVs;
    regQ.push_back(r);
    applyComb(a, b, expR, expF);
  endtask

  initial begin
    int sum;
    int uSum;
    logic [15:0] a16;
    logic [15:0] b16;
    logic [15:0] r16;
    logic [3:0]  f;
    int waitCycles;

    testsRun    = 0;
    testsFailed = 0;
    clkEnable   = 1'b0;
    reset       = 1'b0;
    A           = '0;
    B           = '0;
    #3;

    // Signed sweep, -20..+19 each, no clock activity.
    for (int ia = -20; ia < 20; ia++) begin
      for (int ib = -20; ib < 20; ib++) begin
        a16  = ia[15:0];
        b16  = ib[15:0];
        sum  = ia + ib;
        uSum = int'({16'd0, a16}) + int'({16'd0, b16});
        r16  = uSum[15:0];
        f[3] = (uSum > 65535);
        f[2] = (sum > 32767) || (sum < -32768);
        f[1] = (sum == 0);
        f[0] = (sum < 0);
        applyComb(a16, b16, r16, f);
      end
    end

    // Hand-computed corners, still unclocked.
    applyComb(16'hFFEC, 16'hFFEC, 16'hFFD8, 4'b1001);
    applyComb(16'h7FFF, 16'h0001, 16'h8000, 4'b0101);
    applyComb(16'hFFFF, 16'h0001, 16'h0000, 4'b1010);
    applyComb(16'h8000, 16'h8000, 16'h0000, 4'b1110);

    // Registered phase.
    clkEnable = 1'b1;
    //            rst   A         B         R         CVZN     R_q       flags_q  Vs
    applyStimulus(1'b1, 16'h1234, 16'h1111, 16'h2345, 4'b0000, 16'h0000, 4'b0000, 1'b0);
    applyStimulus(1'b0, 16'h1234, 16'h1111, 16'h2345, 4'b0000, 16'h2345, 4'b0000, 1'b0);
    applyStimulus(1'b0, 16'h7FFF, 16'h0001, 16'h8000, 4'b0101, 16'h8000, 4'b0101, 1'b1);
    applyStimulus(1'b0, 16'h0001, 16'h0001, 16'h0002, 4'b0000, 16'h0002, 4'b0000, 1'b1);
    applyStimulus(1'b0, 16'hFFFF, 16'h0001, 16'h0000, 4'b1010, 16'h0000, 4'b1010, 1'b1);
    applyStimulus(1'b0, 16'hFFEC, 16'hFFEC, 16'hFFD8, 4'b1001, 16'hFFD8, 4'b1001, 1'b1);
    applyStimulus(1'b1, 16'h8000, 16'h8000, 16'h0000, 4'b1110, 16'h0000, 4'b0000, 1'b0);
    applyStimulus(1'b0, 16'h8000, 16'h8000, 16'h0000, 4'b1110, 16'h0000, 4'b1110, 1'b1);
    applyStimulus(1'b0, 16'h0005, 16'h0003, 16'h0008, 4'b0000, 16'h0008, 4'b0000, 1'b1);

    // Let the registered monitor drain, bounded.
    waitCycles = 0;
    while (regQ.size() != 0 && waitCycles < 20) begin
      @(posedge clk);
      #2;
      waitCycles++;
    end
    if (regQ.size() != 0) begin
      checkOutput("reg_queue_drain", regQ.size(), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
